serial_sub16: RTL and testbench

- Bit-serial two's-complement subtractor, the inverse-operation companion to the team's structural 16-bit adder.
- Computes out = A - B one bit per clock, LSB first, as A + ~B + 1.
- Reports the same flag set as the adder: sign, carry, zero, overflow.
- Used where area matters more than latency; sits behind a start/done handshake in the datapath.

---
 rtl/serial_sub16.sv | 179 +++++++++++++++++
 tb/tb_serial_sub16.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub16.sv
// serial_sub16 -- bit-serial two's-complement subtractor (out = A - B).
//
// The difference is formed as A + ~B + 1, one bit per clock, LSB first.
// A start/done handshake wraps the datapath. Result and flags are
// registered once, on the edge that processes the MSB, and hold until
// the next result is registered.
//
// Optional build macro: SERIAL_SUB_SAT_EN
//   defined   -> on signed overflow, out saturates to 7FF..F (A >= 0)
//                or 800..0 (A < 0); sign/zero follow the saturated out,
//                overflow still reports 1, carry stays the raw carry-out.
//   undefined -> out is the wrapped modulo-2^WIDTH result.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request, sampled only in IDLE or DONE
//   A, B     minuend / subtrahend, latched when start is accepted
//   busy     high while the serial loop runs
//   done     one-cycle pulse, result and flags valid
//   out      registered difference
//   sign     out MSB
//   carry    carry-out of A + ~B + 1 (1 = no borrow)
//   zero     out == 0
//   overflow signed overflow of A - B
module serial_sub16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             sign,
    output logic             carry,
    output logic             zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sa_reg, sa_next;
    logic [WIDTH-1:0] sb_reg, sb_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             c_reg, c_next;
    logic             a_msb_reg, a_msb_next;
    logic             b_msb_reg, b_msb_next;
    logic [WIDTH-1:0] out_reg, out_next;
    logic             sign_reg, sign_next;
    logic             carry_reg, carry_next;
    logic             zero_reg, zero_next;
    logic             ovf_reg, ovf_next;

    // Serial full-adder slice and the value the result register would
    // hold once the current bit is shifted in.
    logic             sum_bit;
    logic             carry_bit;
    logic [WIDTH-1:0] res_full;
    logic             ovf_final;
    logic [WIDTH-1:0] out_final;

    always_comb begin
        sum_bit   = sa_reg[0] ^ sb_reg[0] ^ c_reg;
        carry_bit = (sa_reg[0] & sb_reg[0]) | (sa_reg[0] & c_reg) | (sb_reg[0] & c_reg);
        res_full  = {sum_bit, res_reg[WIDTH-1:1]};
        // Operands of different sign whose result sign differs from A.
        ovf_final = (a_msb_reg != b_msb_reg) && (res_full[WIDTH-1] != a_msb_reg);
`ifdef SERIAL_SUB_SAT_EN
        if (ovf_final) begin
            out_final = a_msb_reg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            out_final = res_full;
        end
`else
        out_final = res_full;
`endif
    end

    always_comb begin
        state_next = state_reg;
        sa_next    = sa_reg;
        sb_next    = sb_reg;
        res_next   = res_reg;
        cnt_next   = cnt_reg;
        c_next     = c_reg;
        a_msb_next = a_msb_reg;
        b_msb_next = b_msb_reg;
        out_next   = out_reg;
        sign_next  = sign_reg;
        carry_next = carry_reg;
        zero_next  = zero_reg;
        ovf_next   = ovf_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    sa_next    = A;
                    sb_next    = ~B;
                    c_next     = 1'b1;  // the "+1" of the two's-complement negate
                    cnt_next   = '0;
                    a_msb_next = A[WIDTH-1];
                    b_msb_next = B[WIDTH-1];
                    state_next = RUN;
                end else if (state_reg == DONE) begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                sa_next  = sa_reg >> 1;
                sb_next  = sb_reg >> 1;
                c_next   = carry_bit;
                res_next = res_full;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == LAST_BIT) begin
                    state_next = DONE;
                    out_next   = out_final;
                    sign_next  = out_final[WIDTH-1];
                    carry_next = carry_bit;
                    zero_next  = (out_final == '0);
                    ovf_next   = ovf_final;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            sa_reg    <= '0;
            sb_reg    <= '0;
            res_reg   <= '0;
            cnt_reg   <= '0;
            c_reg     <= 1'b0;
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
            out_reg   <= '0;
            sign_reg  <= 1'b0;
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sa_reg    <= sa_next;
            sb_reg    <= sb_next;
            res_reg   <= res_next;
            cnt_reg   <= cnt_next;
            c_reg     <= c_next;
            a_msb_reg <= a_msb_next;
            b_msb_reg <= b_msb_next;
            out_reg   <= out_next;
            sign_reg  <= sign_next;
            carry_reg <= carry_next;
            zero_reg  <= zero_next;
            ovf_reg   <= ovf_next;
        end
    end

    assign busy     = (state_reg == RUN);
    assign done     = (state_reg == DONE);
    assign out      = out_reg;
    assign sign     = sign_reg;
    assign carry    = carry_reg;
    assign zero     = zero_reg;
    assign overflow = ovf_reg;

endmodule

// File: tb/tb_serial_sub16.sv
// tb_serial_sub16 -- self-checking bench for serial_sub16.
// Table of hand-computed vectors, random operands against an arithmetic
// reference model, plus back-to-back and mid-run abort sequences.
module tb_serial_sub16;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         sign;
    logic         carry;
    logic         zero;
    logic         overflow;

    serial_sub16 #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .A        (a_in),
        .B        (b_in),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .sign     (sign),
        .carry    (carry),
        .zero     (zero),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic         s;
        logic         c;
        logic         z;
        logic         v;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] last_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        vec_t r;
        int   ai, bi;
        ai = $signed(a);
        bi = $signed(b);
        r.a = a;
        r.b = b;
        r.q = W'(int'(a) - int'(b));
        r.c = (int'(a) >= int'(b));
        r.v = ((ai - bi) > 32767) || ((ai - bi) < -32768);
`ifdef SERIAL_SUB_SAT_EN
        if (r.v) r.q = (ai < 0) ? 16'h8000 : 16'h7FFF;
`endif
        r.s = r.q[W-1];
        r.z = (r.q == 0);
        return r;
    endfunction

    task automatic check_result(input string tag, input vec_t e);
        check({tag, ".out"},  32'(out),      32'(e.q));
        check({tag, ".sign"}, 32'(sign),     32'(e.s));
        check({tag, ".carry"},32'(carry),    32'(e.c));
        check({tag, ".zero"}, 32'(zero),     32'(e.z));
        check({tag, ".ovf"},  32'(overflow), 32'(e.v));
    endtask

    // Waits for done after the accepting edge. Returns edge count and
    // number of cycles busy was seen high; out must hold mid-run.
    task automatic wait_done(output int edges, output int busy_cnt, input logic [W-1:0] hold_q);
        edges    = 0;
        busy_cnt = 0;
        while (!done && edges < 40) begin
            if (busy) busy_cnt++;
            if (edges == 8) check("hold_out", 32'(out), 32'(hold_q));
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic run_op(input string tag, input vec_t e);
        int edges, bc;
        @(negedge clk);
        a_in  = e.a;
        b_in  = e.b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a_in  = W'($urandom);   // latched copies only must be used
        b_in  = W'($urandom);
        wait_done(edges, bc, last_q);
        check({tag, ".latency"}, 32'(edges), 32'(W));
        check({tag, ".busy"},    32'(bc),    32'(W));
        check_result(tag, e);
        $display("op %s: %04h - %04h -> out=%04h s=%0d c=%0d z=%0d v=%0d (%0d edges)",
                 tag, e.a, e.b, out, sign, carry, zero, overflow, edges);
        last_q = e.q;
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".out"},  32'(out),      32'd0);
        check({tag, ".flags"},32'({sign, carry, zero, overflow}), 32'd0);
        check({tag, ".busy"}, 32'(busy),     32'd0);
        check({tag, ".done"}, 32'(done),     32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        vec_t e;
        int   edges, bc, seen;

        vecs[0] = '{16'h8FFF, 16'h8000, 16'h0FFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFE, 16'h0002, 16'hFFFC, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0};
`ifdef SERIAL_SUB_SAT_EN
        vecs[4] = '{16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        vecs[4] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1};
`endif

        // Reset with random inputs toggling.
        rst_n = 1'b0;
        start = 1'b1;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        last_q = '0;

        for (int i = 0; i < 6; i++) run_op($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 20; i++) begin
            e = model(W'($urandom), W'($urandom));
            if (i == 0) e = model(16'h0000, 16'h0000);
            run_op($sformatf("rnd%0d", i), e);
        end

        // Back-to-back: start held through the DONE cycle.
        @(negedge clk);
        a_in  = 16'h1234;
        b_in  = 16'h0234;
        start = 1'b1;
        @(posedge clk); #1;
        wait_done(edges, bc, last_q);
        check("b2b_first.latency", 32'(edges), 32'(W));
        check_result("b2b_first", model(16'h1234, 16'h0234));
        last_q = 16'h1000;
        a_in = 16'h0003;
        b_in = 16'h0001;
        @(posedge clk); #1;        // accepted on the edge leaving DONE
        start = 1'b0;
        check("b2b.busy_now", 32'(busy), 32'd1);
        wait_done(edges, bc, last_q);
        check("b2b.gap", 32'(edges + 1), 32'(W + 1));
        check_result("b2b_second", model(16'h0003, 16'h0001));
        $display("op b2b: 0003 - 0001 -> out=%04h (%0d edges after first done)", out, edges + 1);
        @(posedge clk); #1;

        // Abort mid-run.
        @(negedge clk);
        a_in  = 16'h4321;
        b_in  = 16'h1111;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        check("abort.busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("abort.no_done", 32'(seen), 32'd0);
        check_reset_outputs("abort_after");
        $display("op abort: reset during run, done pulses seen=%0d", seen);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
